// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone core-bus arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic arb_owner_t;

    localparam arb_owner_t M_IFETCH = 1'b0;
    localparam arb_owner_t M_DATA   = 1'b1;

    // Tie-break: fixed priority favours the data port, otherwise alternate
    // away from whoever was granted last.
    function automatic arb_owner_t pick_winner(
        input logic       req0,
        input logic       req1,
        input logic       fixed_prio,
        input arb_owner_t last_grant
    );
        arb_owner_t winner;
        if (req0 && req1) begin
            winner = fixed_prio ? M_DATA : arb_owner_t'(~last_grant);
        end else if (req1) begin
            winner = M_DATA;
        end else begin
            winner = M_IFETCH;
        end
        return winner;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts stalled BUSY cycles and flags expiry on the last allowed one.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic wd_unused;
            assign wd_unused = ^{clk, rst_n, clear, enable};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

            logic [CNT_W-1:0] wd_cnt;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt <= '0;
                end else if (clear) begin
                    wd_cnt <= '0;
                end else if (enable && (wd_cnt != CNT_MAX)) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end

            assign expire = enable && (wd_cnt == CNT_LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_core_bus_arbiter.sv
// Two-requester Wishbone-classic arbiter: instruction fetch (m0) and data (m1)
// share one core bus, one whole cyc..ack transaction per grant.
module wb_core_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int ADDR_W         = 32,
    parameter  int DATA_W         = 32,
    parameter  int FIXED_PRIO     = 0,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int SEL_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i
);

    arb_state_t state;
    arb_owner_t owner;
    arb_owner_t last_grant;
    arb_owner_t grant_to;

    logic              req0, req1, busy, timeout;
    logic              own_cyc, own_stb, own_we;
    logic [SEL_W-1:0]  own_sel;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_data;

    assign req0     = m0_cyc_i & m0_stb_i;
    assign req1     = m1_cyc_i & m1_stb_i;
    assign busy     = (state == ARB_BUSY);
    assign grant_to = pick_winner(req0, req1, FIXED_PRIO != 0, last_grant);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        own_cyc  = m0_cyc_i;
        own_stb  = m0_stb_i;
        own_we   = m0_we_i;
        own_sel  = m0_sel_i;
        own_addr = m0_addr_i;
        own_data = m0_data_i;
        if (owner == M_DATA) begin
            own_cyc  = m1_cyc_i;
            own_stb  = m1_stb_i;
            own_we   = m1_we_i;
            own_sel  = m1_sel_i;
            own_addr = m1_addr_i;
            own_data = m1_data_i;
        end
    end

    // Counts only while the owner still holds cyc and the slave has not acked,
    // so an ack on the final cycle beats the timeout.
    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~busy),
        .enable (busy & own_cyc & ~s_ack_i),
        .expire (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            owner      <= M_IFETCH;
            last_grant <= M_DATA;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (req0 || req1) begin
                        state      <= ARB_BUSY;
                        owner      <= grant_to;
                        last_grant <= grant_to;
                    end
                end
                ARB_BUSY: begin
                    if (s_ack_i || !own_cyc || timeout) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Bus is quiet in IDLE; on a timeout cycle cyc/stb are pulled low at once.
    assign s_cyc_o  = busy & own_cyc & ~timeout;
    assign s_stb_o  = busy & own_stb & ~timeout;
    assign s_we_o   = busy & own_we;
    assign s_sel_o  = busy ? own_sel  : '0;
    assign s_addr_o = busy ? own_addr : '0;
    assign s_data_o = busy ? own_data : '0;

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = busy & s_ack_i & (owner == M_IFETCH);
    assign m1_ack_o  = busy & s_ack_i & (owner == M_DATA);
    assign m0_err_o  = timeout & (owner == M_IFETCH);
    assign m1_err_o  = timeout & (owner == M_DATA);

endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// Scoreboard bench: a round-robin/timeout-4 instance driven by directed vectors,
// plus a fixed-priority instance against a zero-wait slave.
module tb_wb_core_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: round-robin, watchdog of 4 cycles
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata, s_rdata;

    wb_core_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_addr_i(m0_addr), .m0_data_i(m0_wdata), .m0_data_o(m0_rdata),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_data_o(m1_rdata),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_data_i(s_rdata), .s_ack_i(s_ack)
    );

    // Instance B: fixed priority, watchdog disabled, zero-wait slave
    logic        b_req;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_s_cyc, b_s_stb, b_s_we, b_s_ack;
    logic [3:0]  b_s_sel;
    logic [31:0] b_s_addr, b_s_wdata;

    assign b_s_ack = b_s_cyc & b_s_stb;

    wb_core_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)
    ) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(b_req), .m0_stb_i(b_req), .m0_we_i(1'b0), .m0_sel_i(4'hF),
        .m0_addr_i(32'h0000_0A00), .m0_data_i(32'h0), .m0_data_o(b_m0_rdata),
        .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m1_cyc_i(b_req), .m1_stb_i(b_req), .m1_we_i(1'b0), .m1_sel_i(4'hF),
        .m1_addr_i(32'h0000_0B00), .m1_data_i(32'h0), .m1_data_o(b_m1_rdata),
        .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
        .s_addr_o(b_s_addr), .s_data_o(b_s_wdata), .s_data_i(32'h5A5A_0001),
        .s_ack_i(b_s_ack)
    );

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    int total = 0;
    int bad = 0;
    int b_m0_cnt = 0;
    int b_m1_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever instance A presents an ack or err.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n) begin
            if (m0_ack || m0_err || m1_ack || m1_err) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got ack0=%b err0=%b ack1=%b err1=%b expected none",
                             m0_ack, m0_err, m1_ack, m1_err);
                end else begin
                    e = sb.pop_front();
                    check("resp_master", {31'd0, m1_ack | m1_err}, {31'd0, e.m});
                    check("resp_err", {31'd0, m0_err | m1_err}, {31'd0, e.err});
                    check("resp_onehot", $countones({m0_ack, m0_err, m1_ack, m1_err}), 1);
                    if (!e.err) check("resp_data", e.m ? m1_rdata : m0_rdata, e.data);
                end
            end
            b_m0_cnt += int'(b_m0_ack);
            b_m1_cnt += int'(b_m1_ack);
        end
    end

    // Plays the slave for one transfer: waits for the grant, checks the
    // address, inserts wait states, acks with data, then expects the dead cycle.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                         input int waits, output int lat);
        int n = 0;
        while (!(s_cyc && s_stb) && n < 20) begin
            tick();
            n++;
        end
        lat = n;
        check("grant_seen", {31'd0, s_cyc & s_stb}, 32'd1);
        check("grant_addr", s_addr, addr);
        repeat (waits) tick();
        s_ack   = 1'b1;
        s_rdata = data;
        tick();
        s_ack   = 1'b0;
        s_rdata = 32'h0;
        check("dead_cycle", {31'd0, s_cyc}, 32'd0);
    endtask

    task automatic check_bus_quiet(input string name);
        check({name, "_ctl"}, {28'd0, s_cyc, s_stb, s_we, 1'b0}, 32'd0);
        check({name, "_sel"}, {28'd0, s_sel}, 32'd0);
        check({name, "_addr"}, s_addr, 32'd0);
        check({name, "_wdata"}, s_wdata, 32'd0);
        check({name, "_resp"}, {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int lat, b0, b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
        {m0_sel, m1_sel} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
        s_ack   = 1'b1;
        s_rdata = 32'h0;
        b_req   = 1'b0;

        // Reset state, with a stray slave ack that must not leak through
        repeat (2) @(negedge clk);
        check_bus_quiet("reset");
        s_ack = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // Fixed priority: m1 wins every tie, one grant every two cycles
        b_req = 1'b1;
        tick();
        tick();
        b0 = b_m0_cnt;
        b1 = b_m1_cnt;
        repeat (20) tick();
        check("fixed_m1_grants", b_m1_cnt - b1, 10);
        check("fixed_m0_grants", b_m0_cnt - b0, 0);

        // Round-robin tie after reset: m0, then m1 (m0 re-requesting), then m0
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_sel = 4'hF; m0_addr = 32'h0000_0200;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_sel = 4'hF; m1_addr = 32'h0000_0300;
        sb.push_back('{1'b0, 1'b0, 32'h1111_0000});
        serve(32'h0000_0200, 32'h1111_0000, 0, lat);
        m0_addr = 32'h0000_0204;
        sb.push_back('{1'b1, 1'b0, 32'h2222_0000});
        sb.push_back('{1'b0, 1'b0, 32'h3333_0000});
        serve(32'h0000_0300, 32'h2222_0000, 0, lat);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        serve(32'h0000_0204, 32'h3333_0000, 0, lat);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // Single m0 read, slave acks one cycle after stb
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0100;
        sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF});
        serve(32'h0000_0100, 32'hDEAD_BEEF, 1, lat);
        check("single_latency", lat, 1);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // Watchdog: slave never acks, err on the 4th BUSY cycle, late ack dropped
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0400;
        sb.push_back('{1'b0, 1'b1, 32'h0});
        tick();
        check("to_busy1", {31'd0, s_cyc}, 32'd1);
        tick();
        tick();
        check("to_busy3", {31'd0, s_cyc}, 32'd1);
        tick();
        check("to_err", {31'd0, m0_err}, 32'd1);
        check("to_cyc_forced", {31'd0, s_cyc | s_stb}, 32'd0);
        tick();
        check("to_after", {31'd0, s_cyc}, 32'd0);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        s_ack = 1'b1; s_rdata = 32'hBAD0_BAD0;
        tick();
        check("late_ack", {31'd0, m0_ack | m0_err}, 32'd0);
        tick();
        s_ack = 1'b0; s_rdata = 32'h0;
        tick();

        // m1 write wins the tie (m0 was last), then abandons; m0 pending goes next
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'b0011;
        m1_addr = 32'h0000_1000; m1_wdata = 32'hCAFE_F00D;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0500;
        tick();
        check("wr_we", {31'd0, s_we}, 32'd1);
        check("wr_sel", {28'd0, s_sel}, 32'h3);
        check("wr_addr", s_addr, 32'h0000_1000);
        check("wr_data", s_wdata, 32'hCAFE_F00D);
        tick();
        m1_cyc = 1'b0;
        #1;
        check("abort_cyc", {31'd0, s_cyc}, 32'd0);
        tick();
        m1_stb = 1'b0; m1_we = 1'b0;
        sb.push_back('{1'b0, 1'b0, 32'h4444_0000});
        serve(32'h0000_0500, 32'h4444_0000, 0, lat);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();

        // Reset mid-BUSY with an ack on the bus: everything drops without an edge
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h0000_0600;
        tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h0000_0700;
        s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check_bus_quiet("mid_reset");
        @(negedge clk);
        s_ack = 1'b0;
        #2 rst_n = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h5555_0000});
        sb.push_back('{1'b1, 1'b0, 32'h6666_0000});
        serve(32'h0000_0600, 32'h5555_0000, 0, lat);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        serve(32'h0000_0700, 32'h6666_0000, 0, lat);
        m1_cyc = 1'b0; m1_stb = 1'b0;

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        check("fixed_m0_total", b_m0_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
